// File: rtl/sprite_commit_pkg.sv
// Shared types and defaults for the sprite commit scheduler: the buffered write
// entry, the scheduler FSM states and the default VGA line limits.
package sprite_commit_pkg;

    localparam int V_ACTIVE_DEFAULT = 480;
    localparam int V_TOTAL_DEFAULT  = 525;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
    } commit_entry_t;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } commit_state_t;

endpackage

// File: rtl/sprite_commit_scheduler_if.sv
// Processor write port and the replayed write port toward the sprite controllers.
// Writes are fire-and-forget strobes: no ready; MW_i/MW_o mean "one write this cycle".
interface sprite_commit_if;
    logic        MW_i;
    logic [29:0] address_i;
    logic [31:0] data_i;
    logic        MW_o;
    logic [29:0] address_o;
    logic [31:0] data_o;

    modport master (output MW_i, address_i, data_i, input MW_o, address_o, data_o);
    modport slave  (input MW_i, address_i, data_i, output MW_o, address_o, data_o);
endinterface

// File: rtl/sprite_commit_scheduler_fifo.sv
// Synchronous FIFO of commit entries; head is read combinationally, full/empty are
// registered alongside the count.
module commit_fifo
    import sprite_commit_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  commit_entry_t              wr_data,
    input  logic                       pop,
    output commit_entry_t              rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    commit_entry_t  mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count_next;

    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // Pointers are AW bits wide, so wrap modulo DEPTH falls out of the arithmetic.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == (AW+1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end
endmodule

// File: rtl/sprite_commit_scheduler.sv
// Holds processor sprite-register writes during active video and replays them in
// vblank so sprites never move mid-frame. `SPRITE_COMMIT_STATS_EN adds drop/frame counters.
module sprite_commit_scheduler
    import sprite_commit_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int V_ACTIVE = V_ACTIVE_DEFAULT,
    parameter int V_TOTAL  = V_TOTAL_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    sprite_commit_if.slave      bus,
    input  logic [31:0]         vga_y_pos_i,
    output logic                full_o,
    output logic                empty_o,
    output logic                overflow_o,
    output logic                frame_commit_o,
`ifdef SPRITE_COMMIT_STATS_EN
    output logic [15:0]         drop_count_o,
    output logic [15:0]         frame_count_o,
`endif
    output commit_state_t       state_o
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          vb, vb_q, vb_rise;
    logic          push, pop, drop, last;
    commit_entry_t head;
    logic [CW-1:0] count;

    // Lines past the frame total are out-of-range and treated as blanking too.
    assign vb      = (vga_y_pos_i >= 32'(V_ACTIVE)) || (vga_y_pos_i >= 32'(V_TOTAL));
    assign vb_rise = vb & ~vb_q;
    assign pop     = (state_o == DRAIN) & vb & ~empty_o;
    assign push    = bus.MW_i & (~full_o | pop);
    assign drop    = bus.MW_i & full_o & ~pop;
    assign last    = pop & ~push & (count == CW'(1));

    commit_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data ({bus.address_i, bus.data_i}),
        .pop     (pop),
        .rd_data (head),
        .full    (full_o),
        .empty   (empty_o),
        .count   (count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_o        <= ACCUM;
            vb_q           <= 1'b1;
            bus.MW_o       <= 1'b0;
            bus.address_o  <= '0;
            bus.data_o     <= '0;
            overflow_o     <= 1'b0;
            frame_commit_o <= 1'b0;
        end else begin
            vb_q           <= vb;
            bus.MW_o       <= pop;
            frame_commit_o <= 1'b0;
            if (drop) overflow_o <= 1'b1;
            if (pop) begin
                bus.address_o <= head.addr;
                bus.data_o    <= head.data;
            end
            case (state_o)
                ACCUM: begin
                    if (vb_rise) begin
                        if (!empty_o) state_o <= DRAIN;
                        else          frame_commit_o <= 1'b1;
                    end
                end
                DRAIN: begin
                    // Leaving early keeps the remainder queued for the next vblank.
                    if (!vb) begin
                        state_o <= ACCUM;
                    end else if (last) begin
                        state_o        <= ACCUM;
                        frame_commit_o <= 1'b1;
                    end
                end
                default: state_o <= ACCUM;
            endcase
        end
    end

`ifdef SPRITE_COMMIT_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_count_o  <= '0;
            frame_count_o <= '0;
        end else begin
            if (drop && drop_count_o != 16'hFFFF) drop_count_o <= drop_count_o + 16'd1;
            if (frame_commit_o) frame_count_o <= frame_count_o + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_sprite_commit_scheduler.sv
// Directed bench for sprite_commit_scheduler: replay order, overflow, early vblank end,
// push during drain, reset mid-drain and (with SPRITE_COMMIT_STATS_EN) the counters.
module tb_sprite_commit_scheduler;
    import sprite_commit_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   y = 32'd100;
    logic          full_o, empty_o, overflow_o, frame_commit_o;
    commit_state_t state_o;
`ifdef SPRITE_COMMIT_STATS_EN
    logic [15:0]   drop_count_o, frame_count_o;
`endif

    sprite_commit_if bus();

    sprite_commit_scheduler #(.DEPTH(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .vga_y_pos_i    (y),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .overflow_o     (overflow_o),
        .frame_commit_o (frame_commit_o),
`ifdef SPRITE_COMMIT_STATS_EN
        .drop_count_o   (drop_count_o),
        .frame_count_o  (frame_count_o),
`endif
        .state_o        (state_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int mw_seen = 0;
    int fc_seen = 0;
    logic [61:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_write(input logic [29:0] a, input logic [31:0] d, input bit keep);
        bus.MW_i      = 1'b1;
        bus.address_i = a;
        bus.data_i    = d;
        if (keep) exp_q.push_back({a, d});
        tick();
        bus.MW_i = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        bit done = 1'b0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            tick();
            if (state_o == ACCUM && !bus.MW_o) done = 1'b1;
        end
        check("drain_done", 64'(done), 64'd1);
    endtask

    // Scoreboard: every replayed write must match the oldest expected entry.
    always @(negedge clk) begin
        if (bus.MW_o) begin
            mw_seen++;
            if (exp_q.size() == 0) check("replay_unexpected", 64'(exp_q.size()), 64'd1);
            else check("replay", 64'({bus.address_o, bus.data_o}), 64'(exp_q.pop_front()));
        end
        if (frame_commit_o) fc_seen++;
    end

    initial begin
        int mw0, fc0;
        bus.MW_i = 1'b1; bus.address_i = 30'h3; bus.data_i = 32'hDEAD;

        // Reset with a write strobe held high
        repeat (3) tick();
        check("rst_mw", 64'(bus.MW_o), 64'd0);
        check("rst_addr", 64'(bus.address_o), 64'd0);
        check("rst_data", 64'(bus.data_o), 64'd0);
        check("rst_full", 64'(full_o), 64'd0);
        check("rst_empty", 64'(empty_o), 64'd1);
        check("rst_ovf", 64'(overflow_o), 64'd0);
        check("rst_fc", 64'(frame_commit_o), 64'd0);
        bus.MW_i = 1'b0;
        rst_n = 1'b1;
        repeat (4) tick();
        check("post_rst_no_mw", 64'(mw_seen), 64'd0);
        check("post_rst_empty", 64'(empty_o), 64'd1);

        // Basic commit: two writes replayed back-to-back in vblank
        drive_write(30'h00000001, 32'hA, 1'b1);
        drive_write(30'h08000002, 32'hB, 1'b1);
        check("basic_not_empty", 64'(empty_o), 64'd0);
        y = 32'd480;
        tick();
        check("basic_state", 64'(state_o), 64'(DRAIN));
        check("basic_mw0", 64'(bus.MW_o), 64'd0);
        tick();
        check("basic_mw1", 64'(bus.MW_o), 64'd1);
        check("basic_data1", 64'(bus.data_o), 64'hA);
        check("basic_fc1", 64'(frame_commit_o), 64'd0);
        tick();
        check("basic_mw2", 64'(bus.MW_o), 64'd1);
        check("basic_addr2", 64'(bus.address_o), 64'h08000002);
        check("basic_data2", 64'(bus.data_o), 64'hB);
        check("basic_fc2", 64'(frame_commit_o), 64'd1);
        check("basic_empty", 64'(empty_o), 64'd1);
        tick();
        check("basic_mw3", 64'(bus.MW_o), 64'd0);
        check("basic_hold", 64'(bus.data_o), 64'hB);
        y = 32'd100;
        tick();

        // Overflow: 17 writes into 16 entries
        for (int i = 0; i < 16; i++) drive_write(30'(i * 4), 32'h100 + 32'(i), 1'b1);
        check("ovf_full", 64'(full_o), 64'd1);
        check("ovf_not_yet", 64'(overflow_o), 64'd0);
        drive_write(30'h3FF, 32'hBAD, 1'b0);
        check("ovf_set", 64'(overflow_o), 64'd1);
        mw0 = mw_seen; fc0 = fc_seen;
        y = 32'd500;
        wait_drain(40);
        check("ovf_replayed", 64'(mw_seen - mw0), 64'd16);
        check("ovf_commit", 64'(fc_seen - fc0), 64'd1);
        check("ovf_q_empty", 64'(exp_q.size()), 64'd0);
        check("ovf_sticky", 64'(overflow_o), 64'd1);
        y = 32'd100;
        tick();

        // Vblank ends after 5 lines of blanking: partial drain, rest next frame
        for (int i = 0; i < 16; i++) drive_write(30'h200 + 30'(i), 32'h200 + 32'(i), 1'b1);
        mw0 = mw_seen; fc0 = fc_seen;
        y = 32'd480;
        repeat (5) tick();
        y = 32'd0;
        repeat (2) tick();
        check("mid_emitted", 64'(mw_seen - mw0), 64'd4);
        check("mid_no_commit", 64'(fc_seen - fc0), 64'd0);
        check("mid_state", 64'(state_o), 64'(ACCUM));
        check("mid_left", 64'(exp_q.size()), 64'd12);
        y = 32'd600;
        wait_drain(40);
        check("mid_rest", 64'(mw_seen - mw0), 64'd16);
        check("mid_commit", 64'(fc_seen - fc0), 64'd1);
        y = 32'd100;
        tick();

        // Push while full during drain: every push pairs with a pop
        for (int i = 0; i < 16; i++) drive_write(30'h300 + 30'(i), 32'h300 + 32'(i), 1'b1);
        mw0 = mw_seen; fc0 = fc_seen;
        y = 32'd480;
        tick();
        for (int i = 0; i < 8; i++) begin
            drive_write(30'h400 + 30'(i), 32'h400 + 32'(i), 1'b1);
            check("pd_full", 64'(full_o), 64'd1);
        end
        wait_drain(40);
        check("pd_emitted", 64'(mw_seen - mw0), 64'd24);
        check("pd_commit", 64'(fc_seen - fc0), 64'd1);
        check("pd_q_empty", 64'(exp_q.size()), 64'd0);
        y = 32'd100;
        tick();

        // Reset mid-drain discards pending entries
        for (int i = 0; i < 3; i++) drive_write(30'h500 + 30'(i), 32'h500 + 32'(i), 1'b1);
        y = 32'd480;
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        exp_q.delete();
        rst_n = 1'b1;
        check("rd_empty", 64'(empty_o), 64'd1);
        check("rd_mw", 64'(bus.MW_o), 64'd0);
        check("rd_ovf", 64'(overflow_o), 64'd0);
        mw0 = mw_seen;
        repeat (3) tick();
        check("rd_no_replay", 64'(mw_seen - mw0), 64'd0);
        y = 32'd100;
        tick();

`ifdef SPRITE_COMMIT_STATS_EN
        check("st_drop_rst", 64'(drop_count_o), 64'd0);
        check("st_frame_rst", 64'(frame_count_o), 64'd0);
        for (int i = 0; i < 16; i++) drive_write(30'h600 + 30'(i), 32'h600 + 32'(i), 1'b1);
        for (int i = 0; i < 3; i++) drive_write(30'h7FF, 32'hBAD, 1'b0);
        y = 32'd480;
        wait_drain(40);
        y = 32'd100;
        tick();
        y = 32'd480;
        repeat (3) tick();
        check("st_drop", 64'(drop_count_o), 64'd3);
        check("st_frame", 64'(frame_count_o), 64'd2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("st_drop_clr", 64'(drop_count_o), 64'd0);
        check("st_frame_clr", 64'(frame_count_o), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sprite_commit_scheduler.md
Name: sprite_commit_scheduler

Overview:
- Sits between the processor write port and the sprite controllers (tank, bullet, score, walls register banks).
- Buffers processor sprite-register writes during active video and replays them during vertical blanking. Sprite position/state updates therefore never change mid-frame, which prevents tearing.
- Its outputs drive the sprite controller's existing MW/address/data inputs unchanged.

Parameters:
- DEPTH, 16: write-buffer entries; power of two, ≥2.
- V_ACTIVE, 480: first non-visible line; vblank = vga_y_pos_i >= V_ACTIVE.
- V_TOTAL, 525: line count per frame; y values ≥ V_TOTAL are treated as vblank.

Ports:
- clk  in  1  single clock (processor clock); all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- MW_i  in  1  processor write strobe, one write per cycle when high.
- address_i  in  30  processor word address; [29:27] selects sprite, [1:0] selects register.
- data_i  in  32  processor write data.
- vga_y_pos_i  in  32  current VGA line, already in clk domain.
- MW_o  out  1  write strobe to sprite controller.
- address_o  out  30  replayed address.
- data_o  out  32  replayed data.
- full_o  out  1  buffer holds DEPTH entries.
- empty_o  out  1  buffer holds 0 entries.
- overflow_o  out  1  sticky; a write was dropped while full.
- frame_commit_o  out  1  one-cycle pulse when a drain finishes with buffer empty.

Behaviour:
- Reset (rst_n low at an edge): MW_o=0, address_o=0, data_o=0, full_o=0, empty_o=1, overflow_o=0, frame_commit_o=0. Buffer is flushed, FSM goes to ACCUM, vblank history register is set to 1. A reset mid-drain discards every pending entry.
- Vblank edge: vb = (vga_y_pos_i >= V_ACTIVE); vb_q is registered. vb_rise = vb & ~vb_q.
- FSM states: ACCUM, DRAIN.
- ACCUM:
  - MW_i pushes {address_i, data_i} if not full.
  - On vb_rise with count>0, go to DRAIN.
  - On vb_rise with count==0, stay in ACCUM and pulse frame_commit_o.
- DRAIN:
  - Each cycle pops the head entry. Registered outputs present it on the next cycle with MW_o=1.
  - Pop latency: an entry popped at edge t is visible at MW_o/address_o/data_o after edge t+1.
  - Exactly one MW_o pulse per popped entry, in FIFO order.
- Leaving DRAIN:
  - Buffer becomes empty (last pop): go to ACCUM and pulse frame_commit_o in the same cycle the last entry is driven.
  - vb falls before empty: go to ACCUM, no pulse. Remaining entries wait for the next vblank; none are lost or reordered.
- Simultaneous push and pop in DRAIN: both occur and count is unchanged. A push while full is accepted only when a pop happens in the same cycle.
- Full without pop: the write is dropped and overflow_o is set. overflow_o clears only on reset.
- Outputs when not issuing: MW_o=0; address_o/data_o hold their last values.
- Pointers wrap modulo DEPTH. Count is log2(DEPTH)+1 bits. full_o = (count==DEPTH); empty_o = (count==0); both are registered and updated in the same cycle as count.

Optional Feature:
- SPRITE_COMMIT_STATS_EN defined:
  - Adds output drop_count_o[15:0]: number of dropped writes, saturating at 16'hFFFF, reset to 0.
  - Adds output frame_count_o[15:0]: increments, wrapping, on each frame_commit_o pulse, reset to 0.
- Not defined: both ports and their counters are absent; all other behaviour is identical.

Decomposition:
- Package sprite_commit_pkg holds:
  - typedef commit_entry_t: packed struct {logic [29:0] addr; logic [31:0] data;}.
  - typedef enum commit_state_t {ACCUM, DRAIN}.
  - localparams V_ACTIVE_DEFAULT=480, V_TOTAL_DEFAULT=525.
- Sub-module commit_fifo: synchronous FIFO of commit_entry_t with push/pop/full/empty/count and parameter DEPTH. The top-level module owns the FSM, vblank edge detection and the output registers.

Test Plan:
- Reset state: hold rst_n=0 for 3 cycles with MW_i=1 -> all outputs at their reset values, empty_o=1, no MW_o pulse after release until a vblank.
- Basic commit: y=100; write (0x00000001, 0xA), (0x08000002, 0xB); step y to 480 -> MW_o high for 2 consecutive cycles carrying A then B, frame_commit_o pulses with the second, empty_o=1.
- Overflow: y=100; issue 17 writes with DEPTH=16 -> full_o=1 after the 16th, overflow_o=1 after the 17th, vblank replays exactly the first 16 in order.
- Vblank ends mid-drain: fill 16; y=480 for 5 cycles, then y=0 -> 4 or 5 entries emitted, no frame_commit_o, remaining 11–12 emitted at the next vblank in order.
- Push during drain: during DRAIN, push 1 write per cycle while full -> count is stable, no drop, all entries emitted once in FIFO order.
- Stats (SPRITE_COMMIT_STATS_EN): 3 dropped writes and 2 completed commits -> drop_count_o=3, frame_count_o=2; after reset both are 0.
